// File: rtl/cic_decim_ctrl_if.sv
// Control/status bundle between the CIC comb sequencer and its host/datapath.
// The slave side is the sequencer; the master side drives run control and rate requests.
interface cic_decim_ctrl_if #(
  parameter int RATE_WIDTH = 8
);
  logic                  enable;
  logic                  sample_strobe;
  logic [RATE_WIDTH-1:0] rate_in;
  logic                  rate_load;
  logic                  hold_strobe;
  logic                  comb_strobe;
  logic                  comb_sel;
  logic                  out_valid_i;
  logic                  out_valid_q;
  logic [RATE_WIDTH-1:0] rate_active;
  logic                  overrun;

  modport master (
    output enable, sample_strobe, rate_in, rate_load,
    input  hold_strobe, comb_strobe, comb_sel, out_valid_i, out_valid_q, rate_active, overrun
  );

  modport slave (
    input  enable, sample_strobe, rate_in, rate_load,
    output hold_strobe, comb_strobe, comb_sel, out_valid_i, out_valid_q, rate_active, overrun
  );
endinterface

// File: rtl/cic_decim_ctrl.sv
// CIC decimator comb-section sequencer: counts samples to each decimation boundary,
// latches I/Q, runs the shared differentiator for I then Q, and flags comb exits.
module cic_decim_ctrl #(
  parameter int RATE_WIDTH   = 8,
  parameter int DEFAULT_RATE = 16,
  parameter int MIN_RATE     = 4,
  parameter int COMB_STAGES  = 4
) (
  input logic             clock,
  input logic             reset,
  cic_decim_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    HOLD   = 3'd2,
    COMB_I = 3'd3,
    COMB_Q = 3'd4
  } state_t;

  localparam logic [RATE_WIDTH-1:0] MIN_RATE_W = RATE_WIDTH'(MIN_RATE);
  localparam logic [RATE_WIDTH-1:0] DEF_RATE_W = RATE_WIDTH'(DEFAULT_RATE);
  localparam logic [RATE_WIDTH-1:0] ONE_W      = RATE_WIDTH'(1'b1);

  state_t                 state_r;
  logic [RATE_WIDTH-1:0]  count_r;
  logic [RATE_WIDTH-1:0]  pending_r;
  logic                   pending_vld_r;
  logic [COMB_STAGES-1:0] line_i_r;
  logic [COMB_STAGES-1:0] line_q_r;
  logic                   boundary_s;
  logic                   in_pair_s;

  function automatic logic [RATE_WIDTH-1:0] clamp_rate(input logic [RATE_WIDTH-1:0] req);
    if (req < MIN_RATE_W) begin
      return MIN_RATE_W;
    end else begin
      return req;
    end
  endfunction

  assign boundary_s = bus.enable && bus.sample_strobe && (count_r == (bus.rate_active - ONE_W));
  assign in_pair_s  = (state_r == HOLD) || (state_r == COMB_I) || (state_r == COMB_Q);

  // Sample counter plus pending/active rate; a new rate only takes effect where the count restarts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r         <= '0;
      pending_r       <= '0;
      pending_vld_r   <= 1'b0;
      bus.rate_active <= DEF_RATE_W;
    end else begin
      if (!bus.enable || boundary_s) begin
        count_r <= '0;
      end else if (bus.sample_strobe) begin
        count_r <= count_r + ONE_W;
      end
      if (bus.rate_load) begin
        pending_r     <= clamp_rate(bus.rate_in);
        pending_vld_r <= 1'b1;
      end else if (pending_vld_r && (boundary_s || !bus.enable)) begin
        bus.rate_active <= pending_r;
        pending_vld_r   <= 1'b0;
      end
    end
  end

  // Pair sequencer; strobes are registered on the transition into the state that owns them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r         <= IDLE;
      bus.hold_strobe <= 1'b0;
      bus.comb_strobe <= 1'b0;
      bus.comb_sel    <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.hold_strobe <= 1'b0;
      bus.comb_strobe <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.enable) begin
            state_r <= COUNT;
          end
        end
        COUNT: begin
          if (boundary_s) begin
            state_r         <= HOLD;
            bus.hold_strobe <= 1'b1;
          end else if (!bus.enable) begin
            state_r <= IDLE;
          end
        end
        HOLD: begin
          state_r         <= COMB_I;
          bus.comb_strobe <= 1'b1;
          bus.comb_sel    <= 1'b0;
        end
        COMB_I: begin
          state_r         <= COMB_Q;
          bus.comb_strobe <= 1'b1;
          bus.comb_sel    <= 1'b1;
        end
        COMB_Q: begin
          state_r <= bus.enable ? COUNT : IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      if (!bus.enable) begin
        bus.overrun <= 1'b0;
      end else if (boundary_s && in_pair_s) begin
        bus.overrun <= 1'b1;
      end
    end
  end

  // Per-channel copy of the comb strobe, aged through the differentiator latency.
  always_ff @(posedge clock) begin
    if (!reset) begin
      line_i_r <= '0;
      line_q_r <= '0;
    end else begin
      line_i_r[0] <= bus.comb_strobe & ~bus.comb_sel;
      line_q_r[0] <= bus.comb_strobe & bus.comb_sel;
      for (int k = 1; k < COMB_STAGES; k++) begin
        line_i_r[k] <= line_i_r[k-1];
        line_q_r[k] <= line_q_r[k-1];
      end
    end
  end

  assign bus.out_valid_i = line_i_r[COMB_STAGES-1];
  assign bus.out_valid_q = line_q_r[COMB_STAGES-1];
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Randomised bench for cic_decim_ctrl: an event-timeline model predicts every output each cycle,
// and directed scenarios pin frame lengths and latencies with hand-computed numbers.
module tb_cic_decim_ctrl;
  localparam int CS  = 4;
  localparam int DEF = 16;
  localparam int MIN = 4;
  localparam int NS  = 8192;

  logic clock;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  cic_decim_ctrl_if #(.RATE_WIDTH(8)) bus ();

  cic_decim_ctrl #(
    .RATE_WIDTH(8), .DEFAULT_RATE(DEF), .MIN_RATE(MIN), .COMB_STAGES(CS)
  ) dut (
    .clock(clock),
    .reset(rst),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model state: interval index, counter/rate bookkeeping and a timeline of scheduled output events.
  int cyc = 0;
  int m_count, m_rate, m_pend, busy_until;
  bit m_pend_v, m_over, m_sel, chk_en;
  bit e_hold, e_comb, e_vi, e_vq;
  bit s_hold [NS];
  bit s_comb [NS];
  bit s_selv [NS];
  bit s_vi   [NS];
  bit s_vq   [NS];
  int hold_q[$];
  int comb_q[$];
  int vi_q[$];
  int vq_q[$];

  task automatic model_step();
    int  k;
    bit  bnd;
    bit  acc;
    k = cyc;
    if (!rst) begin
      for (int j = 1; j <= 3 + CS; j++) begin
        s_hold[k+j] = 1'b0; s_comb[k+j] = 1'b0; s_vi[k+j] = 1'b0; s_vq[k+j] = 1'b0;
      end
      m_count = 0; m_rate = DEF; m_pend_v = 1'b0; m_over = 1'b0; m_sel = 1'b0;
      busy_until = k;
      chk_en = 1'b1;
    end else begin
      bnd = bus.enable && bus.sample_strobe && (m_count == m_rate - 1);
      acc = bnd && (k > busy_until);
      if (acc) begin
        s_hold[k+1] = 1'b1;
        s_comb[k+2] = 1'b1; s_selv[k+2] = 1'b0;
        s_comb[k+3] = 1'b1; s_selv[k+3] = 1'b1;
        s_vi[k+2+CS] = 1'b1;
        s_vq[k+3+CS] = 1'b1;
        busy_until = k + 3;
      end
      if (!bus.enable) m_over = 1'b0;
      else if (bnd && !acc) m_over = 1'b1;
      if (!bus.enable || bnd) m_count = 0;
      else if (bus.sample_strobe) m_count = m_count + 1;
      if (bus.rate_load) begin
        m_pend   = (int'(bus.rate_in) < MIN) ? MIN : int'(bus.rate_in);
        m_pend_v = 1'b1;
      end else if (m_pend_v && (bnd || !bus.enable)) begin
        m_rate   = m_pend;
        m_pend_v = 1'b0;
      end
    end
    cyc    = k + 1;
    e_hold = s_hold[cyc];
    e_comb = s_comb[cyc];
    e_vi   = s_vi[cyc];
    e_vq   = s_vq[cyc];
    if (e_comb) m_sel = s_selv[cyc];
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Single compare process: every output against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("hold_strobe", bus.hold_strobe, e_hold);
        chk("comb_strobe", bus.comb_strobe, e_comb);
        chk("comb_sel", bus.comb_sel, m_sel);
        chk("out_valid_i", bus.out_valid_i, e_vi);
        chk("out_valid_q", bus.out_valid_q, e_vq);
        chk("rate_active", bus.rate_active, m_rate);
        chk("overrun", bus.overrun, m_over);
        if (bus.hold_strobe === 1'b1) hold_q.push_back(cyc);
        if (bus.comb_strobe === 1'b1) comb_q.push_back(cyc);
        if (bus.out_valid_i === 1'b1) vi_q.push_back(cyc);
        if (bus.out_valid_q === 1'b1) vq_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    hold_q.delete(); comb_q.delete(); vi_q.delete(); vq_q.delete();
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  // Advance (enable and strobe already high) until the current interval is a boundary.
  task automatic goto_boundary(input string nm);
    int n;
    n = 0;
    while ((m_count != m_rate - 1) && (n < 64)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL %s no boundary within %0d cycles", nm, n);
    end
  endtask

  int e0;
  int b;
  int dens;

  initial begin
    rst = 1'b0;
    bus.enable = 1'b0; bus.sample_strobe = 1'b0; bus.rate_in = 8'd0; bus.rate_load = 1'b0;
    run(3);
    rst = 1'b1;
    chk("reset_rate", bus.rate_active, 32'd16);
    chk("reset_hold", bus.hold_strobe, 32'd0);

    // Default rate, a sample every cycle
    clear_logs();
    bus.enable = 1'b1; bus.sample_strobe = 1'b1; e0 = cyc;
    run(40);
    chk("first_hold_lat", qat(hold_q, 0) - e0, 32'd16);
    chk("hold_period16", qat(hold_q, 1) - qat(hold_q, 0), 32'd16);
    chk("comb_i_after_hold", qat(comb_q, 0) - qat(hold_q, 0), 32'd1);
    chk("valid_i_after_hold", qat(vi_q, 0) - qat(hold_q, 0), 32'd5);
    chk("valid_q_after_i", qat(vq_q, 0) - qat(vi_q, 0), 32'd1);

    // Mid-frame loads of 2 then 0, both clamp to 4 and wait for the wrap
    bus.rate_load = 1'b1; bus.rate_in = 8'd2;
    tick();
    bus.rate_in = 8'd0;
    tick();
    bus.rate_load = 1'b0;
    chk("rate_held_midframe", bus.rate_active, 32'd16);
    clear_logs();
    run(20);
    chk("no_runt_frame", qat(hold_q, 0) - e0, 32'd48);
    chk("clamped_period", qat(hold_q, 1) - qat(hold_q, 0), 32'd4);
    chk("clamped_rate", bus.rate_active, 32'd4);

    // Rate 4 with a sample every third cycle
    clear_logs();
    for (int i = 0; i < 60; i++) begin
      bus.sample_strobe = (i % 3 == 0);
      tick();
    end
    chk("sparse_period_a", qat(hold_q, 1) - qat(hold_q, 0), 32'd12);
    chk("sparse_period_b", qat(hold_q, 2) - qat(hold_q, 1), 32'd12);
    chk("sparse_overrun", bus.overrun, 32'd0);

    // Load of 8 on the boundary cycle itself
    bus.sample_strobe = 1'b1;
    goto_boundary("load_on_boundary");
    bus.rate_load = 1'b1; bus.rate_in = 8'd8;
    clear_logs();
    tick();
    bus.rate_load = 1'b0;
    chk("rate_kept_at_wrap", bus.rate_active, 32'd4);
    run(30);
    chk("frame_old_rate", qat(hold_q, 1) - qat(hold_q, 0), 32'd4);
    chk("frame_new_rate", qat(hold_q, 2) - qat(hold_q, 1), 32'd8);
    chk("rate_eight", bus.rate_active, 32'd8);

    // Drop enable while the I comb strobe is out
    goto_boundary("disable_mid_pair");
    tick();
    tick();
    bus.enable = 1'b0;
    clear_logs();
    run(30);
    chk("dis_comb_pair", comb_q.size(), 32'd2);
    chk("dis_valid_i", vi_q.size(), 32'd1);
    chk("dis_valid_q", vq_q.size(), 32'd1);
    chk("dis_no_hold", hold_q.size(), 32'd0);

    // Reset while the I comb strobe is out
    bus.enable = 1'b1;
    goto_boundary("reset_mid_pair");
    tick();
    tick();
    rst = 1'b0; bus.enable = 1'b0;
    clear_logs();
    tick();
    rst = 1'b1;
    chk("rst_comb_strobe", bus.comb_strobe, 32'd0);
    chk("rst_comb_sel", bus.comb_sel, 32'd0);
    chk("rst_rate", bus.rate_active, 32'd16);
    run(12);
    chk("rst_no_valid_i", vi_q.size(), 32'd0);
    chk("rst_no_valid_q", vq_q.size(), 32'd0);

    // Randomised traffic; the model checks every cycle
    bus.enable = 1'b1;
    dens = 1;
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) dens = $urandom_range(1, 4);
      rst = ($urandom_range(0, 999) < 4) ? 1'b0 : 1'b1;
      if (bus.enable) bus.enable = ($urandom_range(0, 99) >= 2);
      else            bus.enable = ($urandom_range(0, 99) < 20);
      bus.sample_strobe = ($urandom_range(1, dens) == 1);
      bus.rate_load     = ($urandom_range(0, 39) == 0);
      bus.rate_in       = 8'($urandom_range(0, 20));
      tick();
    end
    rst = 1'b1; bus.rate_load = 1'b0; bus.enable = 1'b0;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
